// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator stage: opcodes, format codes,
// skid-buffer states and the XLEN legality check.
package imm_gen_pipe_pkg;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_Z = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic bit xlenLegal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) valid/ready buffer with flush; output is driven from
// the main entry and in_ready depends only on registered state.
module pipe_skid_buf
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   r_state;
    buf_state_e   w_stateNext;
    logic [W-1:0] r_mainData;
    logic [W-1:0] r_skidData;
    logic         w_accept;
    logic         w_pop;
    logic         w_loadMain;
    logic         w_loadSkid;
    logic         w_skidToMain;

    assign in_ready  = (r_state != BUF_FULL);
    assign out_valid = (r_state != BUF_EMPTY);
    assign out_data  = r_mainData;
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Flush drops both entries; a pop in that cycle is still seen by the consumer.
    always_comb begin
        w_stateNext  = r_state;
        w_loadMain   = 1'b0;
        w_loadSkid   = 1'b0;
        w_skidToMain = 1'b0;
        if (flush) begin
            w_stateNext = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_accept) begin
                        w_loadMain  = 1'b1;
                        w_stateNext = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (w_accept && w_pop) begin
                        w_loadMain = 1'b1;
                    end else if (w_accept) begin
                        w_loadSkid  = 1'b1;
                        w_stateNext = BUF_FULL;
                    end else if (w_pop) begin
                        w_stateNext = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (w_pop) begin
                        w_skidToMain = 1'b1;
                        w_stateNext  = BUF_ONE;
                    end
                end
                default: w_stateNext = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mainData <= '0;
            r_skidData <= '0;
        end else begin
            if (w_loadMain) begin
                r_mainData <= in_data;
            end else if (w_skidToMain) begin
                r_mainData <= r_skidData;
            end
            if (w_loadSkid) begin
                r_skidData <= in_data;
            end
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator with a two-entry skid buffer.
// Define IMM_CSR_EN to decode SYSTEM as the Z (CSR uimm) format.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PAYLOAD_W = XLEN + 3 + TAG_W;

    generate
        if (!xlenLegal(XLEN)) begin : g_badXlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
        if (TAG_W < 1) begin : g_badTag
            $error("imm_gen_pipe: TAG_W must be at least 1");
        end
    endgenerate

    function automatic imm_fmt_e decodeFmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        fmt = FMT_I;
        case (opcode)
            OPCODE_STORE:              fmt = FMT_S;
            OPCODE_BRANCH:             fmt = FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:  fmt = FMT_U;
            OPCODE_JAL:                fmt = FMT_J;
`ifdef IMM_CSR_EN
            OPCODE_SYSTEM:             fmt = FMT_Z;
`else
            OPCODE_SYSTEM:             fmt = FMT_I;
`endif
            default:                   fmt = FMT_I;
        endcase
        return fmt;
    endfunction

    // Every format but Z carries instr[31] in bit 31, so one signed widening covers XLEN=64.
    function automatic logic [XLEN-1:0] buildImm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm32;
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{21{instr[31]}}, instr[30:20]};
            FMT_S: imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            FMT_B: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        if (fmt == FMT_Z) begin
            return XLEN'(instr[19:15]);
        end
        return XLEN'($signed(imm32));
    endfunction

    imm_fmt_e             w_fmt;
    logic [XLEN-1:0]      w_imm;
    logic [PAYLOAD_W-1:0] w_inPayload;
    logic [PAYLOAD_W-1:0] w_outPayload;

    assign w_fmt       = decodeFmt(in_instr[6:0]);
    assign w_imm       = buildImm(in_instr, w_fmt);
    assign w_inPayload = {w_imm, w_fmt, in_tag};

    pipe_skid_buf #(
        .W (PAYLOAD_W)
    ) u_skidBuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_inPayload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_outPayload)
    );

    assign out_imm = w_outPayload[PAYLOAD_W-1 -: XLEN];
    assign out_fmt = w_outPayload[TAG_W +: 3];
    assign out_tag = w_outPayload[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] inInstr;
    logic [7:0]  inTag;
    logic        flushIn;
    logic        outReady;

    logic        inReady32, outValid32;
    logic [31:0] outImm32;
    logic [2:0]  outFmt32;
    logic [7:0]  outTag32;

    logic        inReady64, outValid64;
    logic [63:0] outImm64;
    logic [2:0]  outFmt64;
    logic [7:0]  outTag64;

    int testCount = 0;
    int failCount = 0;
    bit checkEn   = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady32),
        .in_instr(inInstr), .in_tag(inTag), .flush(flushIn),
        .out_valid(outValid32), .out_ready(outReady),
        .out_imm(outImm32), .out_fmt(outFmt32), .out_tag(outTag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady64),
        .in_instr(inInstr), .in_tag(inTag), .flush(flushIn),
        .out_valid(outValid64), .out_ready(outReady),
        .out_imm(outImm64), .out_fmt(outFmt64), .out_tag(outTag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [7:0]  tag;
    } exp_t;

    exp_t expQ[$];
    bit   modelReady;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference immediate: value arithmetic on the signed instruction word.
    function automatic void modelDecode(input logic [31:0] ins, output logic [63:0] imm,
                                        output logic [2:0] fmt);
        longint s;
        longint sgn;
        longint hi;
        s   = longint'($signed(ins));
        sgn = s >>> 31;
        case (ins[6:0])
            7'b0100011: fmt = 3'd1;
            7'b1100011: fmt = 3'd2;
            7'b0110111, 7'b0010111: fmt = 3'd3;
            7'b1101111: fmt = 3'd4;
`ifdef IMM_CSR_EN
            7'b1110011: fmt = 3'd5;
`endif
            default: fmt = 3'd0;
        endcase
        case (fmt)
            3'd0: begin hi = s >>> 20; imm = hi; end
            3'd1: begin hi = s >>> 25; imm = hi * 32 + ins[11:7]; end
            3'd2: imm = sgn * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
            3'd3: imm = s & ~64'hFFF;
            3'd4: imm = sgn * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
            default: imm = {59'b0, ins[19:15]};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expQ.delete();
        end else begin
            exp_t e;
            modelReady = (expQ.size() < 2);
            if (expQ.size() > 0 && outReady) expQ.pop_front();
            if (flushIn) begin
                expQ.delete();
            end else if (inValid && modelReady) begin
                modelDecode(inInstr, e.imm, e.fmt);
                e.tag = inTag;
                expQ.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn && !rst) begin
            checkOutput("out_valid32", outValid32, expQ.size() > 0);
            checkOutput("out_valid64", outValid64, expQ.size() > 0);
            checkOutput("in_ready32", inReady32, expQ.size() < 2);
            checkOutput("in_ready64", inReady64, expQ.size() < 2);
            if (expQ.size() > 0) begin
                checkOutput("imm32", outImm32, expQ[0].imm[31:0]);
                checkOutput("imm64", outImm64, expQ[0].imm);
                checkOutput("fmt32", outFmt32, expQ[0].fmt);
                checkOutput("fmt64", outFmt64, expQ[0].fmt);
                checkOutput("tag32", outTag32, expQ[0].tag);
                checkOutput("tag64", outTag64, expQ[0].tag);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [7:0] tg,
                                 input logic ordy, input logic fl);
        inValid  = v;
        inInstr  = ins;
        inTag    = tg;
        outReady = ordy;
        flushIn  = fl;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        inInstr  = '0;
        inTag    = '0;
        flushIn  = 1'b0;
        outReady = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_out_valid", {outValid32, outValid64}, 2'b00);
        checkOutput("rst_in_ready", {inReady32, inReady64}, 2'b11);
        checkOutput("rst_out_imm64", outImm64, 64'h0);
        checkOutput("rst_out_imm32", outImm32, 32'h0);
        checkOutput("rst_out_fmt", {outFmt32, outFmt64}, 6'h0);
        checkOutput("rst_out_tag", {outTag32, outTag64}, 16'h0);
        rst     = 1'b0;
        checkEn = 1'b1;

        applyStimulus(1'b1, 32'hFFF00093, 8'h11, 1'b1, 1'b0);
        checkOutput("addi_valid", outValid32, 1'b1);
        checkOutput("addi_imm32", outImm32, 32'hFFFFFFFF);
        checkOutput("addi_imm64", outImm64, 64'hFFFFFFFFFFFFFFFF);
        checkOutput("addi_fmt", outFmt32, 3'd0);
        checkOutput("addi_tag", outTag32, 8'h11);

        applyStimulus(1'b1, 32'hFE112E23, 8'h21, 1'b1, 1'b0);
        checkOutput("sw_imm32", outImm32, 32'hFFFFFFFC);
        checkOutput("sw_fmt", outFmt32, 3'd1);
        applyStimulus(1'b1, 32'h123452B7, 8'h22, 1'b1, 1'b0);
        checkOutput("lui_imm32", outImm32, 32'h12345000);
        checkOutput("lui_imm64", outImm64, 64'h0000000012345000);
        checkOutput("lui_fmt", outFmt32, 3'd3);
        applyStimulus(1'b1, 32'h800002B7, 8'h23, 1'b1, 1'b0);
        checkOutput("lui_neg_imm64", outImm64, 64'hFFFFFFFF80000000);
        checkOutput("lui_neg_imm32", outImm32, 32'h80000000);
        applyStimulus(1'b1, 32'hFE000EE3, 8'h24, 1'b1, 1'b0);
        checkOutput("beq_imm32", outImm32, 32'hFFFFFFFC);
        checkOutput("beq_fmt", outFmt32, 3'd2);
        applyStimulus(1'b1, 32'hFF9FF06F, 8'h25, 1'b1, 1'b0);
        checkOutput("jal_imm64", outImm64, 64'hFFFFFFFFFFFFFFF8);
        checkOutput("jal_fmt", outFmt64, 3'd4);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("drain_valid", outValid32, 1'b0);

        // Back-pressure: tags 1,2,3 must come out in order with no loss.
        applyStimulus(1'b1, 32'h00100093, 8'd1, 1'b0, 1'b0);
        checkOutput("bp_ready_after1", inReady32, 1'b1);
        applyStimulus(1'b1, 32'h00200093, 8'd2, 1'b0, 1'b0);
        checkOutput("bp_ready_after2", inReady32, 1'b0);
        checkOutput("bp_hold_tag1", outTag32, 8'd1);
        applyStimulus(1'b1, 32'h00300093, 8'd3, 1'b0, 1'b0);
        checkOutput("bp_still_tag1", outTag32, 8'd1);
        applyStimulus(1'b1, 32'h00300093, 8'd3, 1'b1, 1'b0);
        checkOutput("bp_tag2", outTag32, 8'd2);
        checkOutput("bp_imm2", outImm32, 32'd2);
        applyStimulus(1'b1, 32'h00300093, 8'd3, 1'b1, 1'b0);
        checkOutput("bp_tag3", outTag32, 8'd3);
        checkOutput("bp_imm3", outImm32, 32'd3);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("bp_empty", outValid32, 1'b0);

        // Flush from FULL with an instruction offered in the same cycle.
        applyStimulus(1'b1, 32'h00500093, 8'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600093, 8'd6, 1'b0, 1'b0);
        checkOutput("fl_full", inReady32, 1'b0);
        applyStimulus(1'b1, 32'h00700093, 8'd7, 1'b1, 1'b1);
        checkOutput("fl_valid", outValid32, 1'b0);
        checkOutput("fl_ready", inReady64, 1'b1);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("fl_not_emitted", outValid64, 1'b0);

        applyStimulus(1'b1, 32'h3002D073, 8'h30, 1'b1, 1'b0);
`ifdef IMM_CSR_EN
        checkOutput("csr_imm", outImm32, 32'h00000005);
        checkOutput("csr_fmt", outFmt32, 3'd5);
`else
        checkOutput("csr_imm", outImm32, 32'h00000300);
        checkOutput("csr_fmt", outFmt32, 3'd0);
`endif
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Asynchronous reset while FULL.
        applyStimulus(1'b1, 32'h00800093, 8'd8, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00900093, 8'd9, 1'b0, 1'b0);
        inValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid", {outValid32, outValid64}, 2'b00);
        checkOutput("arst_ready", {inReady32, inReady64}, 2'b11);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h00A00093, 8'h0A, 1'b1, 1'b0);
        checkOutput("arst_resume_valid", outValid32, 1'b1);
        checkOutput("arst_resume_tag", outTag32, 8'h0A);
        checkOutput("arst_resume_imm", outImm64, 64'd10);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
